mem_bus_arbiter: RTL

- Shares the SoC's single-port on-chip RAM between three requesters: the debug loader port, the CPU data bus and the CPU instruction bus.
- The debug port has absolute priority. The CPU data and instruction buses are served round-robin.
- Each requester gets a req/gnt command handshake and a 1-cycle-latency read return. The returned data is routed to whichever requester issued the read.
- Sits between the CPU bus adapters and the RAM. It replaces the current direct mux on the debug memory path.

---
 rtl/mem_bus_pkg.sv | 39 +++
 rtl/mem_bus_arbiter_rr_arb2.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types for the on-chip RAM arbiter: requester identity, the registered
// return tag that routes read data back, and the default RAM window base.
package mem_bus_pkg;

    localparam int NUM_REQ = 3;
    localparam logic [31:0] RAM_BASE_DEFAULT = 32'h0002_0000;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DBG  = 2'd1,
        OWN_DBUS = 2'd2,
        OWN_IBUS = 2'd3
    } owner_t;

    typedef struct packed {
        owner_t owner;
        logic   is_read;
        logic   err;
    } ret_tag_t;

    localparam ret_tag_t TAG_NONE = '{owner: OWN_NONE, is_read: 1'b0, err: 1'b0};

    // Which of the two round-robin ports is preferred next.
    typedef enum logic {
        RR_PORT0 = 1'b0,
        RR_PORT1 = 1'b1
    } rr_ptr_t;

    // Requester index 0/1/2 = debug, CPU data, CPU instruction.
    function automatic owner_t owner_of(input int idx);
        case (idx)
            0:       return OWN_DBG;
            1:       return OWN_DBUS;
            2:       return OWN_IBUS;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a registered preference pointer. The pointer
// moves to the other port after every grant; a disabled arbiter leaves it alone.
module rr_arb2
    import mem_bus_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    rr_ptr_t ptr_reg;
    rr_ptr_t ptr_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg <= RR_PORT0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    always_comb begin
        gnt      = 2'b00;
        ptr_next = ptr_reg;
        if (en) begin
            // A lone requester wins regardless of where the pointer sits.
            if (req[0] && (ptr_reg == RR_PORT0 || !req[1])) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
        if (gnt[0]) begin
            ptr_next = RR_PORT1;
        end else if (gnt[1]) begin
            ptr_next = RR_PORT0;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single-port on-chip RAM between the debug loader (absolute
// priority) and the CPU data/instruction buses (round-robin), and routes reads back.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int               ADR_W     = 32,
    parameter int               RAM_WORDS = 8192,
    parameter logic [ADR_W-1:0] RAM_BASE  = ADR_W'(RAM_BASE_DEFAULT)
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         dbg_req,
    input  logic                         dbg_we,
    input  logic [ADR_W-1:0]             dbg_adr,
    input  logic [31:0]                  dbg_wdata,
    input  logic [3:0]                   dbg_wmask,
    output logic                         dbg_gnt,
    output logic                         dbg_rvalid,
    output logic [31:0]                  dbg_rdata,
    output logic                         dbg_err,

    input  logic                         dbus_req,
    input  logic                         dbus_we,
    input  logic [ADR_W-1:0]             dbus_adr,
    input  logic [31:0]                  dbus_wdata,
    input  logic [3:0]                   dbus_wmask,
    output logic                         dbus_gnt,
    output logic                         dbus_rvalid,
    output logic [31:0]                  dbus_rdata,
    output logic                         dbus_err,

    input  logic                         ibus_req,
    input  logic [ADR_W-1:0]             ibus_adr,
    output logic                         ibus_gnt,
    output logic                         ibus_rvalid,
    output logic [31:0]                  ibus_rdata,
    output logic                         ibus_err,

    output logic [$clog2(RAM_WORDS)-1:0] mem_adr,
    output logic [3:0]                   mem_wren,
    output logic [31:0]                  mem_di,
    input  logic [31:0]                  mem_do,

    input  logic                         dbg_lock
);

    localparam int               MEM_AW    = $clog2(RAM_WORDS);
    localparam logic [ADR_W-1:0] RAM_BYTES = ADR_W'(4 * RAM_WORDS);

    logic [NUM_REQ-1:0] we_vec;
    logic [NUM_REQ-1:0] gnt_vec;
    logic [NUM_REQ-1:0] rvalid_vec;
    logic [NUM_REQ-1:0] err_vec;
    logic [ADR_W-1:0]   adr_arr   [NUM_REQ];
    logic [31:0]        wdata_arr [NUM_REQ];
    logic [3:0]         wmask_arr [NUM_REQ];

    // The instruction bus never writes, so its write fields are tied off.
    assign we_vec       = {1'b0, dbus_we, dbg_we};
    assign adr_arr[0]   = dbg_adr;
    assign adr_arr[1]   = dbus_adr;
    assign adr_arr[2]   = ibus_adr;
    assign wdata_arr[0] = dbg_wdata;
    assign wdata_arr[1] = dbus_wdata;
    assign wdata_arr[2] = 32'h0;
    assign wmask_arr[0] = dbg_wmask;
    assign wmask_arr[1] = dbus_wmask;
    assign wmask_arr[2] = 4'h0;

    // Debug wins outright; with dbg_lock high the CPU side is frozen, pointer included.
    logic       cpu_en;
    logic [1:0] cpu_gnt;

    assign cpu_en = !reset && !dbg_req && !dbg_lock;

    rr_arb2 u_cpu_arb (
        .clk  (clk),
        .srst (reset),
        .en   (cpu_en),
        .req  ({ibus_req, dbus_req}),
        .gnt  (cpu_gnt)
    );

    assign gnt_vec  = {cpu_gnt[1], cpu_gnt[0], dbg_req && !reset};
    assign dbg_gnt  = gnt_vec[0];
    assign dbus_gnt = gnt_vec[1];
    assign ibus_gnt = gnt_vec[2];

    logic             any_gnt;
    logic             sel_we;
    logic [ADR_W-1:0] sel_adr;
    logic [31:0]      sel_wdata;
    logic [3:0]       sel_wmask;
    owner_t           sel_owner;
    logic [ADR_W-1:0] offset;
    logic             in_range;
    ret_tag_t         tag_reg;
    ret_tag_t         tag_next;

    always_comb begin
        sel_we    = 1'b0;
        sel_adr   = '0;
        sel_wdata = 32'h0;
        sel_wmask = 4'h0;
        sel_owner = OWN_NONE;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_vec[i]) begin
                sel_we    = we_vec[i];
                sel_adr   = adr_arr[i];
                sel_wdata = wdata_arr[i];
                sel_wmask = wmask_arr[i];
                sel_owner = owner_of(i);
            end
        end
    end

    assign any_gnt = |gnt_vec;

    // The explicit lower-bound test catches addresses that wrap the subtraction.
    assign offset   = sel_adr - RAM_BASE;
    assign in_range = (sel_adr >= RAM_BASE) && (offset < RAM_BYTES);

    assign mem_adr  = any_gnt ? offset[MEM_AW+1:2] : '0;
    assign mem_wren = (any_gnt && sel_we && in_range && !reset) ? sel_wmask : 4'h0;
    assign mem_di   = sel_wdata;

    always_comb begin
        tag_next = TAG_NONE;
        if (any_gnt) begin
            tag_next = '{owner: sel_owner, is_read: !sel_we, err: !in_range};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_reg <= TAG_NONE;
        end else begin
            tag_reg <= tag_next;
        end
    end

    // Returns are gated by reset so nothing leaks out in the reset cycle itself.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ret
        assign rvalid_vec[gi] = !reset && tag_reg.is_read && (tag_reg.owner == owner_of(gi));
        assign err_vec[gi]    = !reset && tag_reg.err && (tag_reg.owner == owner_of(gi));
    end

    logic [31:0] ret_rdata;

    assign ret_rdata   = (!reset && tag_reg.is_read && !tag_reg.err) ? mem_do : 32'h0;

    assign dbg_rvalid  = rvalid_vec[0];
    assign dbus_rvalid = rvalid_vec[1];
    assign ibus_rvalid = rvalid_vec[2];
    assign dbg_err     = err_vec[0];
    assign dbus_err    = err_vec[1];
    assign ibus_err    = err_vec[2];
    assign dbg_rdata   = ret_rdata;
    assign dbus_rdata  = ret_rdata;
    assign ibus_rdata  = ret_rdata;

endmodule
